// File: rtl/ram_fifo_ctrl.sv
// Synchronous FIFO controller: circular storage in a simple dual-port RAM, fronted by a 2-entry output buffer.
// Define RAM_FIFO_CTRL_BYPASS_EN to let writes into a RAM-empty FIFO skip the RAM (1-cycle latency).
module ram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter              RAM_STYLE  = "auto"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  empty,
  output logic                  full
);
  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W = ADDR_WIDTH + 2;

  (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_pending;
  logic [DATA_WIDTH-1:0] rd_dout;
  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic [DATA_WIDTH-1:0] buf0_next;
  logic [DATA_WIDTH-1:0] buf1_next;
  logic [DATA_WIDTH-1:0] push_data;
  logic [1:0]            buf_cnt;
  logic [1:0]            buf_cnt_pop;
  logic [1:0]            buf_cnt_next;
  logic [CNT_W-1:0]      count_q;
  logic                  ram_empty;
  logic                  ram_full;
  logic                  wr_acc;
  logic                  ram_we;
  logic                  pop;
  logic                  push;
  logic                  rd_issue;
  logic                  bypass;

  // Handshakes, read issue and bypass decision
  always_comb begin
    ram_empty   = (wr_ptr == rd_ptr);
    ram_full    = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                  (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    wr_acc      = in_valid && !ram_full;
    pop         = (buf_cnt != 2'd0) && out_ready;
    buf_cnt_pop = buf_cnt - 2'(pop);
    // Only reserve a buffer slot that is guaranteed free when the data lands
    rd_issue    = !ram_empty && ((buf_cnt_pop + 2'(rd_pending)) < 2'd2);
`ifdef RAM_FIFO_CTRL_BYPASS_EN
    // count==buf_cnt with nothing in flight means the RAM holds nothing older
    bypass      = wr_acc && !rd_pending && (count_q == CNT_W'(buf_cnt)) &&
                  (buf_cnt_pop != 2'd2);
`else
    bypass      = 1'b0;
`endif
    ram_we      = wr_acc && !bypass;
    push        = rd_pending || bypass;
    push_data   = rd_pending ? rd_dout : in_data;
  end

  // Output buffer: shift on pop, then append landing data at the next free slot
  always_comb begin
    buf0_next    = buf0;
    buf1_next    = buf1;
    buf_cnt_next = buf_cnt_pop;
    if (pop) begin
      buf0_next = buf1;
    end
    if (push) begin
      if (buf_cnt_pop == 2'd0) begin
        buf0_next = push_data;
      end else begin
        buf1_next = push_data;
      end
      buf_cnt_next = buf_cnt_pop + 2'd1;
    end
  end

  // RAM array: registered read address gives the 1-cycle read latency
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= in_data;
    end
  end

  assign rd_dout = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_addr    <= '0;
      rd_pending <= 1'b0;
      buf0       <= '0;
      buf1       <= '0;
      buf_cnt    <= 2'd0;
      count_q    <= '0;
    end else begin
      if (ram_we) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_issue) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        rd_addr <= rd_ptr[ADDR_WIDTH-1:0];
      end
      rd_pending <= rd_issue;
      buf0       <= buf0_next;
      buf1       <= buf1_next;
      buf_cnt    <= buf_cnt_next;
      count_q    <= count_q + CNT_W'(wr_acc) - CNT_W'(pop);
    end
  end

  assign in_ready  = !ram_full;
  assign full      = ram_full;
  assign out_data  = buf0;
  assign out_valid = (buf_cnt != 2'd0);
  assign count     = count_q;
  assign empty     = (count_q == '0);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl (DEPTH=4): queue-based reference model plus directed literal checks.
module tb_ram_fifo_ctrl;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = $clog2(DEPTH);
`ifdef RAM_FIFO_CTRL_BYPASS_EN
  localparam bit BYP    = 1'b1;
  localparam int LAT    = 1;
  localparam int STEADY = 1;
`else
  localparam bit BYP    = 1'b0;
  localparam int LAT    = 3;
  localparam int STEADY = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW+1:0] count;
  logic          empty;
  logic          full;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: item counts per stage (RAM, in flight, buffer) and the FIFO contents in order
  int q[$];
  int ram_n = 0;
  int pend  = 0;
  int bufn  = 0;
  logic m_pop, m_wr, m_bp, m_iss;

  assign m_pop = (bufn > 0) && out_ready;
  assign m_wr  = in_valid && (ram_n < int'(DEPTH));
  assign m_bp  = BYP && m_wr && (ram_n == 0) && (pend == 0) && ((bufn - int'(m_pop)) < 2);
  assign m_iss = (ram_n > 0) && ((bufn - int'(m_pop) + pend) < 2);

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      ram_n <= 0;
      pend  <= 0;
      bufn  <= 0;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_wr) q.push_back(int'(in_data));
      ram_n <= ram_n + int'(m_wr && !m_bp) - int'(m_iss);
      pend  <= int'(m_iss);
      bufn  <= bufn - int'(m_pop) + pend + int'(m_bp);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(bufn > 0));
      if (bufn > 0) chk("out_data", 32'(out_data), 32'(q[0]));
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", 32'(empty), 32'(q.size() == 0));
      chk("full", 32'(full), 32'(ram_n == int'(DEPTH)));
      chk("in_ready", 32'(in_ready), 32'(ram_n < int'(DEPTH)));
    end
  end

  // Apply inputs for one cycle and return at the following negedge
  task automatic step(input bit iv, input logic [DW-1:0] d, input bit ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && count != '0; i++) step(1'b0, '0, 1'b1);
    chk(name, 32'(count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rise;
    int sent;
    logic [DW-1:0] rcv[$];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clk);
    step(1'b0, '0, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single item latency
    step(1'b1, 8'hA5, 1'b1);
    rise = -1;
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) chk("single_count_c1", 32'(count), 32'd1);
      if (out_valid && rise < 0) begin
        rise = c;
        chk("single_data", 32'(out_data), 32'hA5);
      end
      step(1'b0, '0, 1'b1);
    end
    chk("single_rise_cycle", 32'(rise), 32'(LAT));
    chk("single_drained", 32'(count), 32'd0);

    // Fill to full; the 7th write must be refused
    for (int i = 0; i < 7; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("fill_count", 32'(count), 32'd6);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_item", 32'(out_data), 32'(i));
      step(1'b0, '0, 1'b1);
    end
    chk("fill_drained", 32'(count), 32'd0);

    // Pointer wrap with random back-pressure
    sent = 0;
    for (int cyc = 0; cyc < 400 && rcv.size() < 20; cyc++) begin
      bit ordy;
      bit iv;
      ordy = 1'($urandom_range(0, 1));
      if (out_valid && ordy) rcv.push_back(out_data);
      iv = (sent < 20);
      if (iv && in_ready) sent++;
      step(iv, DW'(iv ? sent - int'(in_ready) : 0), ordy);
    end
    chk("wrap_received", 32'(rcv.size()), 32'd20);
    for (int i = 0; i < rcv.size(); i++) chk("wrap_item", 32'(rcv[i]), 32'(i));
    drain("wrap_drained");

    // Full throughput with both sides always ready
    for (int c = 0; c < 100; c++) begin
      if (c >= LAT) begin
        chk("tput_valid", 32'(out_valid), 32'd1);
        chk("tput_count", 32'(count), 32'(STEADY));
        chk("tput_data", 32'(out_data), 32'(DW'(c - LAT)));
      end
      step(1'b1, DW'(c), 1'b1);
    end
    drain("tput_drained");

    // Back-pressure hold
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h40 + i), 1'b0);
    for (int i = 0; i < 10 && !out_valid; i++) step(1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'h40);
      step(1'b0, '0, 1'b0);
    end
    step(1'b0, '0, 1'b1);
    chk("release_valid", 32'(out_valid), 32'd1);
    chk("release_data", 32'(out_data), 32'h41);
    drain("hold_drained");

    // Reset mid-stream with a read in flight
    for (int i = 0; i < 6; i++) step(1'b1, DW'(8'h80 + i), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("pre_rst_count", 32'(count), 32'd5);
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    step(1'b1, 8'h3C, 1'b0);
    rise = -1;
    for (int c = 1; c <= 8 && rise < 0; c++) begin
      if (out_valid) begin
        rise = c;
        chk("post_rst_data", 32'(out_data), 32'h3C);
      end else begin
        step(1'b0, '0, 1'b0);
      end
    end
    chk("post_rst_rise", 32'(rise), 32'(LAT));
    drain("post_rst_drained");

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 9) < 7), DW'($urandom), 1'($urandom_range(0, 9) < 6));
    end
    drain("random_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
